// File: rtl/sample_voice_fetch.sv
// Single PCM playback voice: fractional phase, two-tap RAM fetch,
// linear interpolation and valid/ready delivery to the mixer.
module sample_voice_fetch #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 12,
  parameter int STEP_INT   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic [ADDR_WIDTH-1:0]          start_addr,
  input  logic [ADDR_WIDTH-1:0]          loop_addr,
  input  logic [ADDR_WIDTH-1:0]          end_addr,
  input  logic                           loop_en,
  input  logic [STEP_INT+FRAC_WIDTH-1:0] step,
  input  logic                           tick,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_dout,
  output logic [DATA_WIDTH-1:0]          sample_out,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int FW = FRAC_WIDTH;
  localparam int PW = AW + FW;
  localparam int SW = STEP_INT + FW;

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, RD0, RD1, CAP0, CAP1, OUT
  } state_t;

  state_t state;
  logic [PW-1:0] pos;
  logic [DW-1:0] s0;
  logic [DW-1:0] s1;
  logic          fin;

  logic [AW-1:0] ip;
  logic [FW-1:0] fr;
  logic [AW-1:0] nx;
  assign ip = pos[PW-1:FW];
  assign fr = pos[FW-1:0];

  always_comb begin
    nx = end_addr;
    if (ip < end_addr)
      nx = ip + AW'(1);
    else if (loop_en)
      nx = loop_addr;
  end

  logic signed [DW:0]      diff;
  logic signed [DW+FW+1:0] prod;
  logic signed [DW+FW+1:0] shf;
  logic [DW-1:0]           interp;

  assign diff = $signed({s1[DW-1], s1}) - $signed({s0[DW-1], s0});
  assign prod = diff * $signed({1'b0, fr});
  assign shf = prod >>> FW;
  // Result is bounded by s0/s1, so truncation cannot wrap
  assign interp = s0 + shf[DW-1:0];

  logic [PW:0]   np;
  logic [AW:0]   ni;
  logic [AW:0]   ea;
  logic [AW:0]   wrap;
  logic [AW:0]   wrap_c;
  logic          past_end;

  assign np = {1'b0, pos} + {{(PW + 1 - SW){1'b0}}, step};
  assign ni = np[PW:FW];
  assign ea = {1'b0, end_addr};
  assign past_end = ni > ea;
  assign wrap = {1'b0, loop_addr} + ni - ea - (AW + 1)'(1);
  assign wrap_c = (wrap > ea) ? {1'b0, loop_addr} : wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pos          <= '0;
      s0           <= '0;
      s1           <= '0;
      fin          <= 1'b0;
      mem_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= tick &&
                 !(state == WAIT_TICK && !sample_valid);
      if (stop) begin
        state        <= IDLE;
        sample_valid <= 1'b0;
        busy         <= 1'b0;
        fin          <= 1'b0;
      end else if (start) begin
        state        <= WAIT_TICK;
        pos          <= {start_addr, {FW{1'b0}}};
        sample_valid <= 1'b0;
        busy         <= 1'b1;
        fin          <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          WAIT_TICK: begin
            if (tick && !sample_valid) begin
              mem_addr <= ip;
              state    <= RD0;
            end
          end
          RD0: begin
            mem_addr <= nx;
            state    <= RD1;
          end
          RD1: begin
            s0    <= mem_dout;
            state <= CAP0;
          end
          CAP0: begin
            s1    <= mem_dout;
            state <= CAP1;
          end
          CAP1: begin
            sample_out   <= interp;
            sample_valid <= 1'b1;
            state        <= OUT;
            if (!past_end)
              pos <= np[PW-1:0];
            else if (loop_en)
              pos <= {wrap_c[AW-1:0], np[FW-1:0]};
            else
              fin <= 1'b1;
          end
          OUT: begin
            if (sample_ready) begin
              sample_valid <= 1'b0;
              if (fin) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                fin   <= 1'b0;
                state <= IDLE;
              end else begin
                state <= WAIT_TICK;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_voice_fetch.sv
// Bench for sample_voice_fetch: behavioural voice model checked every
// cycle, plus literal sample expectations for each playback scenario.
module tb_sample_voice_fetch;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int FW = 12;
  localparam int SI = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] loop_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          loop_en = 1'b0;
  logic [SI+FW-1:0] step = '0;
  logic          tick = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          sample_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          overrun;

  sample_voice_fetch #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .FRAC_WIDTH(FW), .STEP_INT(SI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .stop(stop),
    .start_addr(start_addr), .loop_addr(loop_addr),
    .end_addr(end_addr), .loop_en(loop_en),
    .step(step), .tick(tick),
    .mem_addr(mem_addr), .mem_dout(mem_dout),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) mem_dout <= mem[mem_addr];

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Voice model: a fetch countdown instead of an explicit state machine
  longint m_pos;
  bit     m_busy, m_valid, m_fin, m_done, m_ovr;
  int     m_cnt;
  int     m_out;

  function automatic int rd(input longint a);
    int v;
    v = mem[int'(a)];
    return v;
  endfunction

  task automatic produce();
    longint ip, fr, nx, np, ni, t;
    int s0, s1;
    ip = m_pos >> FW;
    fr = m_pos % 4096;
    if (ip < end_addr) nx = ip + 1;
    else nx = loop_en ? loop_addr : end_addr;
    s0 = rd(ip);
    s1 = rd(nx);
    m_out = s0 + (((s1 - s0) * int'(fr)) >>> FW);
    np = m_pos + step;
    ni = np >> FW;
    if (ni <= end_addr) m_pos = np;
    else if (loop_en) begin
      t = loop_addr + (ni - end_addr - 1);
      if (t > end_addr) t = loop_addr;
      m_pos = (t << FW) + (np % 4096);
    end else m_fin = 1;
    m_valid = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_busy = 0; m_valid = 0; m_fin = 0;
      m_done = 0; m_ovr = 0; m_cnt = 0; m_out = 0;
    end else begin
      m_done = 0;
      m_ovr = tick && !(m_busy && !m_valid && m_cnt == 0);
      if (stop) begin
        m_busy = 0; m_valid = 0; m_cnt = 0; m_fin = 0;
      end else if (start) begin
        m_busy = 1; m_valid = 0; m_cnt = 0; m_fin = 0;
        m_pos = longint'(start_addr) << FW;
      end else if (m_busy) begin
        if (m_valid) begin
          if (sample_ready) begin
            m_valid = 0;
            if (m_fin) begin
              m_done = 1; m_busy = 0; m_fin = 0;
            end
          end
        end else if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) produce();
        end else if (tick) m_cnt = 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", sample_valid, m_valid);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("overrun", overrun, m_ovr);
    chk("sample_out", $signed(sample_out), m_out);
    if (done) done_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic do_start(input logic [AW-1:0] sa);
    @(negedge clk);
    start_addr = sa;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
  endtask

  task automatic collect(input string name, input int exp,
                         input bit accept);
    int n = 0;
    while (!sample_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sample_valid) chk({name, "_timeout"}, 0, 1);
    else chk(name, $signed(sample_out), exp);
    if (accept) @(negedge clk);
  endtask

  task automatic get(input string name, input int exp);
    pulse_tick();
    collect(name, exp, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[19'h100] = 16'sd1000;
    mem[19'h101] = 16'sd2000;
    mem[19'h102] = 16'sd3000;
    mem[19'h103] = 16'sd4000;
    mem[19'h200] = -16'sd100;
    mem[19'h201] = -16'sd201;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_addr", mem_addr, 0);
    #2 rst_n = 1'b1;

    // Unity pitch one-shot
    end_addr = 19'h103; loop_addr = 19'h100;
    loop_en = 1'b0; step = 16'h1000;
    done_cnt = 0;
    do_start(19'h100);
    get("unity0", 1000);
    get("unity1", 2000);
    get("unity2", 3000);
    get("unity3", 4000);
    repeat (2) @(negedge clk);
    chk("unity_done_cnt", done_cnt, 1);
    chk("unity_busy", busy, 0);

    // Half pitch
    step = 16'h0800;
    do_start(19'h100);
    get("half0", 1000);
    get("half1", 1500);
    get("half2", 2000);
    get("half3", 2500);
    get("half4", 3000);
    do_stop();

    // Negative interpolation, floor rounding
    end_addr = 19'h201;
    do_start(19'h200);
    get("neg0", -100);
    get("neg1", -151);
    get("neg2", -201);
    do_stop();

    // Looped playback
    end_addr = 19'h103; loop_addr = 19'h101;
    loop_en = 1'b1; step = 16'h1000;
    done_cnt = 0;
    do_start(19'h100);
    get("loop0", 1000);
    get("loop1", 2000);
    get("loop2", 3000);
    get("loop3", 4000);
    get("loop4", 2000);
    get("loop5", 3000);
    chk("loop_no_done", done_cnt, 0);
    do_stop();
    step = 16'h1800;
    do_start(19'h102);
    get("loopfr0", 3000);
    get("loopfr1", 3000);
    do_stop();

    // Backpressure and dropped ticks
    loop_en = 1'b0; step = 16'h1000;
    ovr_cnt = 0;
    sample_ready = 1'b0;
    do_start(19'h100);
    pulse_tick();
    collect("bp0", 1000, 1'b0);
    pulse_tick();
    repeat (2) @(negedge clk);
    pulse_tick();
    repeat (2) @(negedge clk);
    chk("bp_hold", $signed(sample_out), 1000);
    chk("bp_valid", sample_valid, 1);
    chk("bp_ovr_cnt", ovr_cnt, 2);
    sample_ready = 1'b1;
    @(negedge clk);
    pulse_tick();
    chk("bp_addr", mem_addr, 19'h101);
    collect("bp1", 2000, 1'b1);
    do_stop();

    // Restart during CAP0
    do_start(19'h100);
    pulse_tick();
    repeat (2) @(negedge clk);
    start_addr = 19'h102;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    chk("restart_valid", sample_valid, 0);
    get("restart", 3000);

    // stop beats start
    @(negedge clk);
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    chk("stopstart_busy", busy, 0);

    // Asynchronous reset in RD1
    do_start(19'h100);
    pulse_tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", mem_addr, 0);
    chk("arst_out", $signed(sample_out), 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", sample_valid, 0);
    do_start(19'h101);
    get("post_rst", 2000);
    do_stop();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
